// File: rtl/tlb_assoc.sv
// -----------------------------------------------------------------------------
// tlb_assoc
//
// Fully-associative translation lookaside buffer. It maps virtual page numbers
// (VPN) to physical page numbers (PPN). A hit answers with a registered
// translation one cycle after the request is accepted. A miss raises a
// page-walk request on a valid/ack handshake. It then installs the returned
// PPN and answers one cycle after the ack edge. Flush-all and single-VPN
// invalidate are supported.
//
// Optional build feature:
//   TLB_STATS_EN - when defined, saturating hit/miss counters are built.
//                  When undefined, hit_count/miss_count are constant 0 and no
//                  counter flops exist.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   req_valid    lookup request
//   req_vpn      VPN to translate
//   req_ready    block can accept a request (IDLE and no flush)
//   resp_valid   one-cycle pulse, translation ready
//   resp_ppn     translated PPN, held until the next response
//   resp_hit     1 = served from the TLB, 0 = served from a page walk
//   walk_valid   page-walk request pending
//   walk_vpn     VPN being walked
//   walk_ack     walk result present this cycle
//   walk_ppn     walk result
//   flush        invalidate all entries
//   inval_valid  invalidate one VPN
//   inval_vpn    VPN to invalidate
//   hit_count    accepted hits since reset (saturating)
//   miss_count   accepted misses since reset (saturating)
// -----------------------------------------------------------------------------
module tlb_assoc #(
  parameter int VPN_W   = 10,
  parameter int PPN_W   = 6,
  parameter int ENTRIES = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [VPN_W-1:0] req_vpn,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [PPN_W-1:0] resp_ppn,
  output logic             resp_hit,
  output logic             walk_valid,
  output logic [VPN_W-1:0] walk_vpn,
  input  logic             walk_ack,
  input  logic [PPN_W-1:0] walk_ppn,
  input  logic             flush,
  input  logic             inval_valid,
  input  logic [VPN_W-1:0] inval_vpn,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] valid_next;
  logic [VPN_W-1:0]   tag_vpn [ENTRIES];
  logic [PPN_W-1:0]   tag_ppn [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               has_free;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   victim_idx;

  logic               accept_hit;
  logic               accept_miss;
  logic               walk_done;
  logic               walk_flushed;
  logic               do_install;

  // Associative lookup. All valid entries are compared against the incoming
  // VPN in parallel. Fills only happen on a miss, so at most one entry can
  // match. Because of that, the index can simply be taken from whichever
  // comparator fires.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && (tag_vpn[i] == req_vpn)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Victim choice for a fill. An empty slot is always preferred, and the
  // lowest-index one wins (the scan runs downward, so the last assignment
  // is the smallest index). Only when the buffer is full does the
  // round-robin pointer pick the entry to evict.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    victim_idx = has_free ? free_idx : rr_ptr;
  end

  // Control FSM, next-state half. IDLE accepts requests whenever no flush is
  // in progress. A hit stays in IDLE so hits can stream one per cycle. A miss
  // moves to WALK and waits there for walk_ack. Acks that arrive in IDLE
  // fall through the case untouched.
  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    accept_hit  = 1'b0;
    accept_miss = 1'b0;
    walk_done   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~flush;
        if (req_valid && !flush) begin
          if (hit) begin
            accept_hit = 1'b1;
          end else begin
            accept_miss = 1'b1;
            state_next  = WALK;
          end
        end
      end
      WALK: begin
        if (walk_ack) begin
          walk_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control FSM, state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign walk_valid = (state == WALK);

  // A flush seen at any point in a walk means the walk's answer must not be
  // installed. Otherwise a translation fetched before the flush could survive
  // it. The flush on the ack edge itself is covered directly in do_install.
  assign do_install = walk_done && !flush && !walk_flushed;

  // Remember whether a flush happened while the current walk was outstanding.
  // The flag is cleared when a new walk starts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      walk_flushed <= 1'b0;
    end else if (accept_miss) begin
      walk_flushed <= 1'b0;
    end else if ((state == WALK) && flush) begin
      walk_flushed <= 1'b1;
    end
  end

  // Next valid vector. A flush wipes everything. Otherwise a matching
  // invalidate clears its entry, and a fill applied afterwards wins when
  // both target the same slot on one edge. The lookup uses the pre-edge
  // vector, so a request and an invalidate of the same VPN on one edge
  // still see a hit.
  always_comb begin
    valid_next = valid;
    if (flush) begin
      valid_next = '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (inval_valid && valid[i] && (tag_vpn[i] == inval_vpn)) begin
          valid_next[i] = 1'b0;
        end
      end
      if (do_install) begin
        valid_next[victim_idx] = 1'b1;
      end
    end
  end

  // Valid bits and the replacement pointer. The pointer only moves when a
  // fill actually evicts a live entry, so filling an empty slot leaves it
  // where it is.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid  <= '0;
      rr_ptr <= '0;
    end else begin
      valid <= valid_next;
      if (do_install && !has_free) begin
        rr_ptr <= rr_ptr + IDX_W'(1);
      end
    end
  end

  // Entry payload storage. Tags and PPNs are not reset. A stale tag is
  // harmless because every use of an entry is gated by its valid bit.
  always_ff @(posedge clock) begin
    if (do_install) begin
      tag_vpn[victim_idx] <= walk_vpn;
      tag_ppn[victim_idx] <= walk_ppn;
    end
  end

  // Walk address register. It captures the missing VPN at acceptance and
  // holds it stable for the whole walk.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      walk_vpn <= '0;
    end else if (accept_miss) begin
      walk_vpn <= req_vpn;
    end
  end

  // Response register. resp_valid is a single-cycle pulse. The PPN and hit
  // flag are held between responses so a slow consumer sees stable data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_ppn   <= '0;
      resp_hit   <= 1'b0;
    end else begin
      resp_valid <= accept_hit | walk_done;
      if (accept_hit) begin
        resp_ppn <= tag_ppn[hit_idx];
        resp_hit <= 1'b1;
      end else if (walk_done) begin
        resp_ppn <= walk_ppn;
        resp_hit <= 1'b0;
      end
    end
  end

`ifdef TLB_STATS_EN
  // Statistics. The counters count accepted hits and accepted misses. They
  // stick at all-ones instead of wrapping, and only reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (accept_hit && (hit_count != {CNT_W{1'b1}})) begin
        hit_count <= hit_count + CNT_W'(1);
      end
      if (accept_miss && (miss_count != {CNT_W{1'b1}})) begin
        miss_count <= miss_count + CNT_W'(1);
      end
    end
  end
`else
  // Statistics disabled: both counters read as zero.
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_tlb_assoc.sv
// -----------------------------------------------------------------------------
// tb_tlb_assoc
//
// Self-checking bench for tlb_assoc. A behavioural TLB model tracks the
// entries as simple arrays, updated once per transaction. A random page table
// supplies walk answers. Directed scenarios are followed by a randomized
// mix of lookups, flushes and invalidates.
// -----------------------------------------------------------------------------
module tb_tlb_assoc;

  localparam int VPN_W   = 10;
  localparam int PPN_W   = 6;
  localparam int ENTRIES = 8;
  localparam int CNT_W   = 16;
`ifdef TLB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic [VPN_W-1:0] req_vpn = '0;
  logic             req_ready;
  logic             resp_valid;
  logic [PPN_W-1:0] resp_ppn;
  logic             resp_hit;
  logic             walk_valid;
  logic [VPN_W-1:0] walk_vpn;
  logic             walk_ack = 1'b0;
  logic [PPN_W-1:0] walk_ppn = '0;
  logic             flush = 1'b0;
  logic             inval_valid = 1'b0;
  logic [VPN_W-1:0] inval_vpn = '0;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  tlb_assoc #(
    .VPN_W  (VPN_W),
    .PPN_W  (PPN_W),
    .ENTRIES(ENTRIES),
    .CNT_W  (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_vpn    (req_vpn),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ppn   (resp_ppn),
    .resp_hit   (resp_hit),
    .walk_valid (walk_valid),
    .walk_vpn   (walk_vpn),
    .walk_ack   (walk_ack),
    .walk_ppn   (walk_ppn),
    .flush      (flush),
    .inval_valid(inval_valid),
    .inval_vpn  (inval_vpn),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  // Reference state: page table plus a transaction-level TLB model.
  logic [PPN_W-1:0] page_table [1024];
  bit               m_valid [ENTRIES];
  logic [VPN_W-1:0] m_vpn   [ENTRIES];
  logic [PPN_W-1:0] m_ppn   [ENTRIES];
  int               m_ptr;
  int               m_hits;
  int               m_misses;

  // Results of the last lookup.
  logic [PPN_W-1:0] r_ppn;
  logic             r_hit;
  int               r_lat;
  int               r_wf;
  logic [VPN_W-1:0] r_wv;
  bit               r_wu;
  bit               r_rdy;
  bit               r_to;
  bit               e_hit;
  logic [PPN_W-1:0] e_ppn;

  // Reference model: clears all model state, as a DUT reset does.
  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_ptr    = 0;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  // Reference model: drops every cached translation.
  function automatic void model_flush();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
  endfunction

  // Reference model: drops the translation for one VPN, if cached.
  function automatic void model_inval(input logic [VPN_W-1:0] v);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_vpn[i] == v) m_valid[i] = 1'b0;
  endfunction

  // Reference model: one complete lookup. On a miss the translation comes
  // from the page table and is installed in a free slot or the round-robin
  // slot, unless a flush happened during the walk.
  function automatic void model_access(input logic [VPN_W-1:0] v, input bit flushed,
                                       output bit hit, output logic [PPN_W-1:0] ppn);
    int slot;
    hit = 1'b0;
    ppn = page_table[v];
    slot = -1;
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_vpn[i] == v) begin hit = 1'b1; ppn = m_ppn[i]; end
    if (hit) begin
      m_hits++;
    end else begin
      m_misses++;
      if (flushed) begin
        model_flush();
      end else begin
        for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
        if (slot < 0) begin slot = m_ptr; m_ptr = (m_ptr + 1) % ENTRIES; end
        m_valid[slot] = 1'b1;
        m_vpn[slot]   = v;
        m_ppn[slot]   = page_table[v];
      end
    end
  endfunction

  // Applies reset across two clock edges and resets the model with it.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // Issues one request and acts as the page walker. The walk is acked
  // ack_delay cycles after walk_valid first appears. If flush_at >= 0, a
  // flush is pulsed flush_at cycles into the walk. The task records what
  // it observes; the wait is bounded at 200 cycles.
  task automatic lookup(input logic [VPN_W-1:0] vpn, input int ack_delay, input int flush_at,
                        output logic [PPN_W-1:0] ppn, output logic hit, output int lat,
                        output int walk_first, output logic [VPN_W-1:0] walk_vpn_seen,
                        output bit walk_unstable, output bit ready_at_resp, output bit timeout);
    int waited;
    ppn = '0; hit = 1'b0; lat = -1; walk_first = -1; walk_vpn_seen = '0;
    walk_unstable = 1'b0; ready_at_resp = 1'b0; timeout = 1'b1; waited = 0;
    @(negedge clock);
    req_vpn   = vpn;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (resp_valid) begin
        ppn = resp_ppn; hit = resp_hit; lat = c; ready_at_resp = req_ready;
        if (walk_valid) walk_unstable = 1'b1;
        timeout = 1'b0;
        break;
      end
      if (walk_valid) begin
        if (walk_first < 0) begin
          walk_first = c;
          walk_vpn_seen = walk_vpn;
        end else if (walk_vpn !== walk_vpn_seen) begin
          walk_unstable = 1'b1;
        end
        if (req_ready !== 1'b0) walk_unstable = 1'b1;
        if (waited == flush_at) flush = 1'b1;
        if (waited == ack_delay) begin
          walk_ack = 1'b1;
          walk_ppn = page_table[walk_vpn];
        end
        waited++;
      end
      @(posedge clock);
      #1;
      walk_ack = 1'b0;
      flush    = 1'b0;
      walk_ppn = PPN_W'($urandom);
    end
  endtask

  // Checks that every output holds its reset value.
  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready got=%b exp=1", req_ready); else passes++;
    checks++; if (resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid got=%b exp=0", resp_valid); else passes++;
    checks++; if (resp_ppn !== '0) $display("[TB] FAIL reset_resp_ppn got=%h exp=0", resp_ppn); else passes++;
    checks++; if (resp_hit !== 1'b0) $display("[TB] FAIL reset_resp_hit got=%b exp=0", resp_hit); else passes++;
    checks++; if (walk_valid !== 1'b0) $display("[TB] FAIL reset_walk_valid got=%b exp=0", walk_valid); else passes++;
    checks++; if (walk_vpn !== '0) $display("[TB] FAIL reset_walk_vpn got=%h exp=0", walk_vpn); else passes++;
    checks++; if (hit_count !== '0) $display("[TB] FAIL reset_hit_count got=%0d exp=0", hit_count); else passes++;
    checks++; if (miss_count !== '0) $display("[TB] FAIL reset_miss_count got=%0d exp=0", miss_count); else passes++;
  endtask

  // First request for VPN 0x005 misses and is served by a walk that returns 0x2A.
  task automatic test_first_miss();
    lookup(10'h005, 0, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
    model_access(10'h005, 1'b0, e_hit, e_ppn);
    checks++; if (r_to !== 1'b0) $display("[TB] FAIL miss_timeout got=%b exp=0", r_to); else passes++;
    checks++; if (r_wf !== 0) $display("[TB] FAIL miss_walk_start got=%0d exp=0", r_wf); else passes++;
    checks++; if (r_wv !== 10'h005) $display("[TB] FAIL miss_walk_vpn got=%h exp=005", r_wv); else passes++;
    checks++; if (r_ppn !== 6'h2A) $display("[TB] FAIL miss_ppn got=%h exp=2a", r_ppn); else passes++;
    checks++; if (r_hit !== 1'b0) $display("[TB] FAIL miss_hit got=%b exp=0", r_hit); else passes++;
    checks++; if (r_lat !== 1) $display("[TB] FAIL miss_latency got=%0d exp=1", r_lat); else passes++;
    checks++; if (r_rdy !== 1'b1) $display("[TB] FAIL miss_ready_at_resp got=%b exp=1", r_rdy); else passes++;
    checks++; if (r_wu !== 1'b0) $display("[TB] FAIL miss_walk_drop got=%b exp=0", r_wu); else passes++;
  endtask

  // Repeat lookups of VPN 0x005 hit; back-to-back hits give one response per cycle.
  task automatic test_hit_back_to_back();
    lookup(10'h005, 0, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
    model_access(10'h005, 1'b0, e_hit, e_ppn);
    checks++; if (r_hit !== 1'b1) $display("[TB] FAIL hit_flag got=%b exp=1", r_hit); else passes++;
    checks++; if (r_ppn !== 6'h2A) $display("[TB] FAIL hit_ppn got=%h exp=2a", r_ppn); else passes++;
    checks++; if (r_lat !== 0) $display("[TB] FAIL hit_latency got=%0d exp=0", r_lat); else passes++;
    checks++; if (r_wf !== -1) $display("[TB] FAIL hit_walk_seen got=%0d exp=-1", r_wf); else passes++;
    @(negedge clock);
    req_vpn   = 10'h005;
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      if (k == 3) req_valid = 1'b0;
      @(negedge clock);
      model_access(10'h005, 1'b0, e_hit, e_ppn);
      checks++;
      if ({resp_valid, resp_hit, resp_ppn, walk_valid} !== {1'b1, 1'b1, 6'h2A, 1'b0})
        $display("[TB] FAIL b2b_resp_%0d got v=%b h=%b p=%h w=%b exp v=1 h=1 p=2a w=0",
                 k, resp_valid, resp_hit, resp_ppn, walk_valid);
      else passes++;
    end
    @(negedge clock);
    checks++; if (resp_valid !== 1'b0) $display("[TB] FAIL b2b_tail got=%b exp=0", resp_valid); else passes++;
  endtask

  // Fills VPNs 0x10..0x17, then walks the round-robin replacement sequence.
  task automatic test_replacement();
    logic [VPN_W-1:0] seq_vpn [7];
    bit               seq_hit [7];
    logic [VPN_W-1:0] v;
    seq_vpn = '{10'h020, 10'h010, 10'h012, 10'h011, 10'h012, 10'h010, 10'h020};
    seq_hit = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      v = 10'h010 + VPN_W'(i);
      lookup(v, $urandom_range(0, 2), -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
      model_access(v, 1'b0, e_hit, e_ppn);
      checks++;
      if ({r_to, r_hit, r_ppn} !== {1'b0, 1'b0, page_table[v]})
        $display("[TB] FAIL fill_%h got to=%b h=%b p=%h exp to=0 h=0 p=%h", v, r_to, r_hit, r_ppn, page_table[v]);
      else passes++;
    end
    for (int i = 0; i < 7; i++) begin
      v = seq_vpn[i];
      lookup(v, 1, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
      model_access(v, 1'b0, e_hit, e_ppn);
      checks++;
      if ({r_to, r_hit, r_ppn} !== {1'b0, seq_hit[i], page_table[v]})
        $display("[TB] FAIL replace_%0d_%h got to=%b h=%b p=%h exp to=0 h=%b p=%h",
                 i, v, r_to, r_hit, r_ppn, seq_hit[i], page_table[v]);
      else passes++;
    end
  endtask

  // A 20-cycle walk holds walk_valid/walk_vpn stable with req_ready low, then yields one response.
  task automatic test_long_walk();
    lookup(10'h055, 20, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
    model_access(10'h055, 1'b0, e_hit, e_ppn);
    checks++; if (r_wu !== 1'b0) $display("[TB] FAIL long_walk_stable got=%b exp=0", r_wu); else passes++;
    checks++; if (r_wv !== 10'h055) $display("[TB] FAIL long_walk_vpn got=%h exp=055", r_wv); else passes++;
    checks++; if (r_lat !== 21) $display("[TB] FAIL long_walk_latency got=%0d exp=21", r_lat); else passes++;
    checks++; if ({r_hit, r_ppn} !== {1'b0, page_table[10'h055]})
      $display("[TB] FAIL long_walk_resp got h=%b p=%h exp h=0 p=%h", r_hit, r_ppn, page_table[10'h055]); else passes++;
    @(negedge clock);
    checks++; if ({resp_valid, walk_valid} !== 2'b00)
      $display("[TB] FAIL long_walk_single got v=%b w=%b exp 00", resp_valid, walk_valid); else passes++;
  endtask

  // A flush during the walk for 0x033 still delivers the response but installs nothing.
  task automatic test_flush_walk();
    lookup(10'h033, 3, 1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
    model_access(10'h033, 1'b1, e_hit, e_ppn);
    checks++; if ({r_to, r_hit, r_ppn} !== {1'b0, 1'b0, page_table[10'h033]})
      $display("[TB] FAIL flush_walk_resp got to=%b h=%b p=%h exp to=0 h=0 p=%h", r_to, r_hit, r_ppn, page_table[10'h033]); else passes++;
    lookup(10'h033, 0, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
    model_access(10'h033, 1'b0, e_hit, e_ppn);
    checks++; if (r_hit !== 1'b0) $display("[TB] FAIL flush_walk_not_installed got=%b exp=0", r_hit); else passes++;
    lookup(10'h010, 0, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
    model_access(10'h010, 1'b0, e_hit, e_ppn);
    checks++; if (r_hit !== 1'b0) $display("[TB] FAIL flush_walk_old_entry got=%b exp=0", r_hit); else passes++;
  endtask

  // Covers invalidate alone, invalidate on the same edge as a hitting request, and walk_ack in IDLE.
  task automatic test_inval();
    @(negedge clock);
    inval_valid = 1'b1;
    inval_vpn   = 10'h010;
    @(posedge clock);
    #1;
    inval_valid = 1'b0;
    model_inval(10'h010);
    lookup(10'h010, 0, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
    model_access(10'h010, 1'b0, e_hit, e_ppn);
    checks++; if (r_hit !== 1'b0) $display("[TB] FAIL inval_then_miss got=%b exp=0", r_hit); else passes++;
    @(negedge clock);
    req_vpn     = 10'h010;
    req_valid   = 1'b1;
    inval_valid = 1'b1;
    inval_vpn   = 10'h010;
    @(posedge clock);
    #1;
    req_valid   = 1'b0;
    inval_valid = 1'b0;
    @(negedge clock);
    model_access(10'h010, 1'b0, e_hit, e_ppn);
    model_inval(10'h010);
    checks++; if ({resp_valid, resp_hit, resp_ppn} !== {1'b1, 1'b1, page_table[10'h010]})
      $display("[TB] FAIL inval_same_edge got v=%b h=%b p=%h exp v=1 h=1 p=%h",
               resp_valid, resp_hit, resp_ppn, page_table[10'h010]); else passes++;
    lookup(10'h010, 0, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
    model_access(10'h010, 1'b0, e_hit, e_ppn);
    checks++; if (r_hit !== 1'b0) $display("[TB] FAIL inval_same_edge_cleared got=%b exp=0", r_hit); else passes++;
    @(negedge clock);
    walk_ack = 1'b1;
    walk_ppn = 6'h3F;
    @(posedge clock);
    #1;
    walk_ack = 1'b0;
    @(negedge clock);
    checks++; if ({resp_valid, walk_valid} !== 2'b00)
      $display("[TB] FAIL idle_ack_ignored got v=%b w=%b exp 00", resp_valid, walk_valid); else passes++;
    lookup(10'h010, 0, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
    model_access(10'h010, 1'b0, e_hit, e_ppn);
    checks++; if ({r_hit, r_ppn} !== {1'b1, page_table[10'h010]})
      $display("[TB] FAIL idle_ack_entry got h=%b p=%h exp h=1 p=%h", r_hit, r_ppn, page_table[10'h010]); else passes++;
  endtask

  // Three hits and two misses after reset: counters show 3 and 2 when stats are built.
  task automatic test_stats();
    do_reset();
    lookup(10'h040, 0, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
    model_access(10'h040, 1'b0, e_hit, e_ppn);
    for (int i = 0; i < 3; i++) begin
      lookup(10'h040, 0, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
      model_access(10'h040, 1'b0, e_hit, e_ppn);
    end
    lookup(10'h041, 2, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
    model_access(10'h041, 1'b0, e_hit, e_ppn);
    @(negedge clock);
    checks++; if (hit_count !== CNT_W'(STATS ? 3 : 0))
      $display("[TB] FAIL stats_hits got=%0d exp=%0d", hit_count, STATS ? 3 : 0); else passes++;
    checks++; if (miss_count !== CNT_W'(STATS ? 2 : 0))
      $display("[TB] FAIL stats_misses got=%0d exp=%0d", miss_count, STATS ? 2 : 0); else passes++;
  endtask

  // Random mix of lookups, occasional flushes mid-walk, idle flushes and invalidates.
  task automatic test_random();
    logic [VPN_W-1:0] v;
    int               op;
    int               d;
    int               fa;
    int               exp_lat;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 99);
      v  = 10'h100 + VPN_W'($urandom_range(0, 13));
      if (op < 85 || op >= 95) begin
        d  = $urandom_range(0, 3);
        fa = (op >= 95) ? $urandom_range(0, d) : -1;
        lookup(v, d, fa, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
        model_access(v, fa >= 0, e_hit, e_ppn);
        exp_lat = e_hit ? 0 : d + 1;
        checks++;
        if ({r_to, r_hit, r_ppn} !== {1'b0, e_hit, e_ppn})
          $display("[TB] FAIL rand_%0d_%h got to=%b h=%b p=%h exp to=0 h=%b p=%h",
                   n, v, r_to, r_hit, r_ppn, e_hit, e_ppn);
        else passes++;
        checks++;
        if (r_lat !== exp_lat) $display("[TB] FAIL rand_lat_%0d got=%0d exp=%0d", n, r_lat, exp_lat);
        else passes++;
      end else if (op < 88) begin
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        model_flush();
      end else begin
        @(negedge clock);
        inval_valid = 1'b1;
        inval_vpn   = v;
        @(posedge clock);
        #1;
        inval_valid = 1'b0;
        model_inval(v);
      end
    end
    @(negedge clock);
    checks++; if (hit_count !== CNT_W'(STATS ? m_hits : 0))
      $display("[TB] FAIL rand_hits got=%0d exp=%0d", hit_count, STATS ? m_hits : 0); else passes++;
    checks++; if (miss_count !== CNT_W'(STATS ? m_misses : 0))
      $display("[TB] FAIL rand_misses got=%0d exp=%0d", miss_count, STATS ? m_misses : 0); else passes++;
  endtask

  // Reset in the middle of a walk clears outputs at once; no response follows and entries are gone.
  task automatic test_reset_mid_walk();
    bit seen;
    lookup(10'h060, 0, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
    model_access(10'h060, 1'b0, e_hit, e_ppn);
    lookup(10'h060, 0, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
    model_access(10'h060, 1'b0, e_hit, e_ppn);
    @(negedge clock);
    req_vpn   = 10'h061;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    checks++; if (walk_valid !== 1'b1) $display("[TB] FAIL midwalk_started got=%b exp=1", walk_valid); else passes++;
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({walk_valid, resp_valid} !== 2'b00)
      $display("[TB] FAIL midwalk_reset_outputs got w=%b v=%b exp 00", walk_valid, resp_valid); else passes++;
    checks++; if ({hit_count, miss_count} !== '0)
      $display("[TB] FAIL midwalk_reset_counters got h=%0d m=%0d exp 0 0", hit_count, miss_count); else passes++;
    @(negedge clock);
    reset    = 1'b0;
    walk_ack = 1'b1;
    walk_ppn = 6'h15;
    model_reset();
    @(posedge clock);
    #1;
    walk_ack = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (resp_valid !== 1'b0 || walk_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("[TB] FAIL midwalk_no_response got=%b exp=0", seen); else passes++;
    lookup(10'h060, 0, -1, r_ppn, r_hit, r_lat, r_wf, r_wv, r_wu, r_rdy, r_to);
    model_access(10'h060, 1'b0, e_hit, e_ppn);
    checks++; if ({r_to, r_hit} !== 2'b00)
      $display("[TB] FAIL midwalk_entries_cleared got to=%b h=%b exp 00", r_to, r_hit); else passes++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) page_table[i] = PPN_W'($urandom);
    page_table[10'h005] = 6'h2A;
    model_reset();
    test_reset();
    test_first_miss();
    test_hit_back_to_back();
    test_replacement();
    test_long_walk();
    test_flush_walk();
    test_inval();
    test_stats();
    test_random();
    test_reset_mid_walk();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Bounds total run time in case the design stalls beyond the per-lookup limits.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
